// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared constants, arbitration mode type and round-robin pick helper
package fifo_arb_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // One-hot winner: first set bit of elig at or above start, wrapping modulo n (n <= 8).
    // Walking the offsets downward lets the smallest offset overwrite any later match.
    function automatic logic [7:0] rr_pick(input logic [7:0] elig, input logic [2:0] start, input int n);
        logic [7:0] win;
        int         j;
        win = '0;
        for (int k = 7; k >= 0; k--) begin
            j = (int'(start) + k) % n;
            if (k < n && elig[j[2:0]]) win = 8'b1 << j[2:0];
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: combinational winner selection, round-robin from start or fixed lowest-index
//   elig  in  N       eligible requesters
//   start in  IW      first index searched in round-robin mode
//   mode  in  1       ARB_RR / ARB_FIXED
//   gnt   out N       one-hot winner (0 when elig is 0)
//   idx   out IW      index of the winner
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter  int N  = N_REQ_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] start,
    input  arb_mode_e     mode,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        gnt = N'(rr_pick(8'(elig), mode == ARB_FIXED ? 3'd0 : 3'(start), N));
        idx = '0;
        for (int i = 0; i < N; i++) idx = gnt[i] ? IW'(i) : idx;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port between N_REQ producers with full/almostfull throttling
//   clk             in  1                system clock
//   rst_n           in  1                synchronous active-low reset
//   req             in  N_REQ            per-producer request, data held until ack
//   req_data        in  N_REQ*FIFO_WIDTH packed producer words, slice i = requester i
//   req_mask        in  N_REQ            1 = requester eligible
//   prio_mode       in  1                0 = round-robin, 1 = fixed lowest-index priority
//   fifo_full       in  1                FIFO full flag
//   fifo_almostfull in  1                FIFO one-slot-left flag
//   ack             out N_REQ            combinational one-hot grant
//   wr_en           out 1                registered FIFO write enable
//   data_in         out FIFO_WIDTH       registered FIFO write data
//   starve          out N_REQ            sticky starvation flags
//   last_gnt        out $clog2(N_REQ)    most recent winner (round-robin pointer)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_mask,
    input  logic                        prio_mode,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    output logic [N_REQ-1:0]            ack,
    output logic                        wr_en,
    output logic [FIFO_WIDTH-1:0]       data_in,
    output logic [N_REQ-1:0]            starve,
    output logic [$clog2(N_REQ)-1:0]    last_gnt
);

    localparam int              IW   = $clog2(N_REQ);
    localparam int              CW   = $clog2(MAX_WAIT + 2);
    localparam logic [IW-1:0]   LAST = IW'(N_REQ - 1);
    localparam logic [CW-1:0]   SAT  = CW'(MAX_WAIT);

    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
    logic [IW-1:0]         last_gnt_q, last_gnt_d;
    logic [N_REQ-1:0]      starve_q, starve_d;
    logic [CW-1:0]         cnt_q [N_REQ];
    logic [CW-1:0]         cnt_d [N_REQ];
    logic                  can_wr;
    logic [N_REQ-1:0]      elig, gnt;
    logic [IW-1:0]         start, gnt_idx;

    // A write registered last cycle is not yet reflected in almostfull, so it consumes the last slot.
    always_comb begin
        can_wr = !fifo_full && !(fifo_almostfull && wr_en_q);
        elig   = req & req_mask;
        start  = last_gnt_q == LAST ? '0 : last_gnt_q + 1'b1;
    end

    rr_select #(.N(N_REQ)) u_sel (
        .elig  (elig),
        .start (start),
        .mode  (arb_mode_e'(prio_mode)),
        .gnt   (gnt),
        .idx   (gnt_idx)
    );

    always_comb begin
        ack        = rst_n && can_wr ? gnt : '0;
        wr_en_d    = |ack;
        data_in_d  = wr_en_d ? req_data[gnt_idx*FIFO_WIDTH +: FIFO_WIDTH] : data_in_q;
        last_gnt_d = wr_en_d ? gnt_idx : last_gnt_q;
        starve_d   = starve_q;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i]    = ack[i] || !elig[i] ? '0 : cnt_q[i] == SAT ? cnt_q[i] : cnt_q[i] + 1'b1;
            starve_d[i] = starve_q[i] || (elig[i] && !ack[i] && cnt_q[i] == SAT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            data_in_q  <= '0;
            last_gnt_q <= LAST;
            starve_q   <= '0;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            data_in_q  <= data_in_d;
            last_gnt_q <= last_gnt_d;
            starve_q   <= starve_d;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign wr_en    = wr_en_q;
    assign data_in  = data_in_q;
    assign starve   = starve_q;
    assign last_gnt = last_gnt_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the FIFO (data_in/wr_en) between N producers.
- Uses a per-requester req/ack handshake and throttles on the FIFO's full/almostfull flags, so no write is ever issued into a full FIFO.
- Sits directly in front of the FIFO's write side; the read side (rd_en) is untouched.
- Also provides a per-requester enable mask, a fixed-priority debug mode and sticky starvation flags.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FIFO_WIDTH, 16, data width, equal to the FIFO data_in width.
- MAX_WAIT, 15, cycles a masked-in requester may wait with req high before its starve flag sets.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  N_REQ  request per producer; held high with stable data until acked.
- req_data  in  N_REQ*FIFO_WIDTH  packed data; slice i belongs to requester i.
- req_mask  in  N_REQ  1 = requester eligible, 0 = ignored (no grant, no starvation count).
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO almostfull flag (one slot left).
- ack  out  N_REQ  combinational one-hot grant; the producer sees its word accepted on this clock edge.
- wr_en  out  1  registered FIFO write enable.
- data_in  out  FIFO_WIDTH  registered FIFO write data.
- starve  out  N_REQ  sticky per-requester starvation flag.
- last_gnt  out  $clog2(N_REQ)  index of the most recent grant (round-robin pointer).

Behaviour:
- Reset (rst_n=0 at posedge): wr_en=0, data_in=0, starve=0, last_gnt=N_REQ-1 (first RR search starts at index 0), all wait counters=0. ack is forced to 0 while rst_n=0.
- Accept condition: can_wr = !fifo_full && !(fifo_almostfull && wr_en). This covers the one-cycle lag between a registered write and the flag update.
- Eligible set: elig = req & req_mask.
- Grant selection, combinational:
  - if can_wr and elig!=0:
    - prio_mode=0: first set bit of elig searching from last_gnt+1 upward, wrapping modulo N_REQ.
    - prio_mode=1: lowest set bit of elig.
  - ack = one-hot of the winner; otherwise ack=0.
- At posedge with a grant to index g: wr_en<=1, data_in<=req_data[g], last_gnt<=g.
- At posedge with no grant: wr_en<=0, data_in holds its value, last_gnt holds.
- Latency: the word reaches the FIFO pins 1 cycle after ack; maximum throughput is 1 word/cycle.
- Producer rule: after seeing ack at an edge, the producer drops req or presents the next word. Arbiter behaviour when data changes without ack is undefined.
- Wait counters, per requester, saturating at MAX_WAIT:
  - Cleared when ack[i], req[i]=0 or req_mask[i]=0.
  - Incremented when elig[i] && !ack[i].
  - When the counter equals MAX_WAIT with a further wait cycle, starve[i]<=1 (sticky until reset).
- Boundaries:
  - Full for many cycles: no ack, wr_en=0, waiting counters run.
  - almostfull with a write in flight: grant suppressed one cycle.
  - Pointer wraps from N_REQ-1 to 0.
  - Single eligible requester: granted every accepting cycle.
  - Mask cleared on a requester with req high: never granted, no starve.
  - prio_mode toggled mid-stream: takes effect in the same cycle; last_gnt is still updated so RR resumes from the last winner.
  - Reset mid-operation: outputs return to reset values on that edge; any pending request is regranted after release.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - constants N_REQ_DEF=4 and MAX_WAIT_DEF=15;
  - typedef arb_mode_e {ARB_RR=0, ARB_FIXED=1};
  - function rr_pick(elig, start) returning the one-hot winner.
- One natural sub-module: rr_select (combinational, parameterized N). It takes elig, start index and mode, and returns the one-hot winner plus its index. The top module holds the pointer, output registers and wait counters.

Test Plan:
- Fairness: req=4'b1111 held, mask=1111, mode=0, FIFO never full -> ack sequence 0001,0010,0100,1000,0001; wr_en=1 every cycle; data_in follows with 1-cycle lag.
- Throttle: fifo_full=1 for 5 cycles with req=0011 -> ack=0 and wr_en=0 for all 5. Then almostfull=1 with full=0: one write issued, the next cycle's grant is suppressed.
- Fixed priority: mode=1, req=1010 held -> requester 1 acked each cycle and requester 3 never. With MAX_WAIT=15, starve[3] rises after 16 waiting cycles and stays 1 after req[3] drops.
- Mask: req=1111, mask=0101 -> acks alternate 0001,0100 only; starve[1] and starve[3] remain 0.
- Reset mid-stream: assert rst_n=0 during grants -> at the next edge wr_en=0, data_in=0, last_gnt=3, starve=0. After release with req=1000, the first ack is 1000, and data_in equals req_data[3] one cycle later.
- Random: 90000 cycles of random req/mask/full/almostfull with a scoreboard. Check:
  - FIFO-side word order equals ack order;
  - no wr_en while fifo_full;
  - ack is one-hot or zero.
